// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, widths,
// PC step and the fetch FSM state encoding used by decode/cu as well.
package ifu_pkg;

  localparam int XLEN_LENGTH = 64;
  localparam int INST_LENGTH = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Byte distance between consecutive sequential instructions.
  localparam int INST_STEP = INST_LENGTH / 8;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  // Word-align a fetch address by clearing its two low bits.
  function automatic logic [XLEN_LENGTH-1:0] align_pc(input logic [XLEN_LENGTH-1:0] addr);
    return addr & ~XLEN_LENGTH'(3);
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// Program counter register: reset value, sequential +4 advance and
// redirect mux. A redirect always wins over the sequential advance.
module ifu_pc
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_LENGTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  // PC update: redirect target (word aligned) or pc+4, wrapping modulo 2^XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target & ~XLEN'(3);
    end else if (advance) begin
      pc <= pc + XLEN'(INST_STEP);
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding instruction-memory request at a
// time, registered instruction buffer towards decode, and redirect handling
// that squashes any fetch on the old path via the kill flag.
module ifu
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_LENGTH,
  parameter int              INST_W   = INST_LENGTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o_ifu,
  input  logic              imem_req_ready_i_ifu,
  output logic [XLEN-1:0]   imem_req_addr_o_ifu,
  input  logic              imem_resp_valid_i_ifu,
  input  logic [INST_W-1:0] imem_resp_data_i_ifu,
  input  logic              pcsel_i_ifu,
  input  logic [XLEN-1:0]   target_i_ifu,
  output logic              inst_valid_o_ifu,
  input  logic              inst_ready_i_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic [XLEN-1:0]   pc_o_ifu
);

  ifu_state_e        state;
  logic              req_valid;
  logic              kill;
  logic              inst_valid;
  logic [INST_W-1:0] inst_buf;
  logic [XLEN-1:0]   pc_buf;
  logic [XLEN-1:0]   pc;
  logic              advance;

  // The PC only steps sequentially when decode takes the buffered instruction;
  // a same-cycle redirect overrides this inside ifu_pc.
  assign advance = (state == S_OUT) && inst_ready_i_ifu;

  ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .redirect (pcsel_i_ifu),
    .target   (target_i_ifu),
    .pc       (pc)
  );

  // Fetch FSM, kill flag and output buffer. A response arriving while the
  // fetch is killed (or being killed this cycle) is dropped and a fresh
  // request is issued from the redirected PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      req_valid  <= 1'b1;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst_buf   <= '0;
      pc_buf     <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready_i_ifu) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
            kill      <= pcsel_i_ifu;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid_i_ifu) begin
            if (kill || pcsel_i_ifu) begin
              kill      <= 1'b0;
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else begin
              inst_buf   <= imem_resp_data_i_ifu;
              pc_buf     <= pc;
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end else if (pcsel_i_ifu) begin
            kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (inst_ready_i_ifu || pcsel_i_ifu) begin
            inst_valid <= 1'b0;
            state      <= S_REQ;
            req_valid  <= 1'b1;
          end
        end
        default: begin
          state      <= S_REQ;
          req_valid  <= 1'b1;
          kill       <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_o_ifu = req_valid;
  assign imem_req_addr_o_ifu  = pc;
  assign inst_valid_o_ifu     = inst_valid;
  assign inst_o_ifu           = inst_buf;
  assign pc_o_ifu             = pc_buf;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: a directed cycle table, two hand-written multi-cycle
// sequences (decode stall, reset while waiting) and a randomized run
// checked against a transaction-level fetch model.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        pcsel;
  logic [63:0] target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc_o;

  int n_chk;
  int n_fail;

  ifu #(
    .XLEN     (64),
    .INST_W   (32),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_req_valid_o_ifu  (req_valid),
    .imem_req_ready_i_ifu  (req_ready),
    .imem_req_addr_o_ifu   (req_addr),
    .imem_resp_valid_i_ifu (resp_valid),
    .imem_resp_data_i_ifu  (resp_data),
    .pcsel_i_ifu           (pcsel),
    .target_i_ifu          (target),
    .inst_valid_o_ifu      (inst_valid),
    .inst_ready_i_ifu      (inst_ready),
    .inst_o_ifu            (inst),
    .pc_o_ifu              (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ps;
    logic [63:0] tg;
    logic        ir;
    logic        ev;
    logic [63:0] ea;
    logic        eiv;
    logic [31:0] ei;
    logic [63:0] ep;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ps, input logic [63:0] tg, input logic ir,
                              input logic ev, input logic [63:0] ea, input logic eiv,
                              input logic [31:0] ei, input logic [63:0] ep);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ps = ps; v.tg = tg; v.ir = ir;
    v.ev = ev; v.ea = ea; v.eiv = eiv; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ps, input logic [63:0] tg, input logic ir);
    req_ready  = rr;
    resp_valid = rv;
    resp_data  = rd;
    pcsel      = ps;
    target     = tg;
    inst_ready = ir;
  endtask

  // Memory contents used by the randomized run.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // Transaction-level model state for the randomized run.
  logic [63:0] m_pc;
  logic        m_outst;
  logic        m_live;
  logic [63:0] m_out_addr;
  logic        m_buf;
  logic [63:0] m_buf_pc;
  logic [31:0] m_buf_inst;
  int          m_deliv;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

    // rr rv rd ps tg ir | ev ea eiv ei ep
    tbl[0]  = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0000,0,32'h0,       64'h0);
    tbl[1]  = mk(0,1,32'h0000_0013,0,64'h0,         1, 0,64'h8000_0000,0,32'h0,       64'h0);
    tbl[2]  = mk(0,0,32'h0,        0,64'h0,         1, 0,64'h8000_0000,1,32'h13,      64'h8000_0000);
    tbl[3]  = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0004,0,32'h13,      64'h8000_0000);
    tbl[4]  = mk(0,1,32'h0010_0093,0,64'h0,         1, 0,64'h8000_0004,0,32'h13,      64'h8000_0000);
    tbl[5]  = mk(0,0,32'h0,        0,64'h0,         1, 0,64'h8000_0004,1,32'h0010_0093,64'h8000_0004);
    tbl[6]  = mk(0,0,32'h0,        1,64'h8000_0103, 1, 1,64'h8000_0008,0,32'h0010_0093,64'h8000_0004);
    tbl[7]  = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0100,0,32'h0010_0093,64'h8000_0004);
    tbl[8]  = mk(0,1,32'h0020_0113,0,64'h0,         1, 0,64'h8000_0100,0,32'h0010_0093,64'h8000_0004);
    tbl[9]  = mk(0,0,32'h0,        1,64'h8000_0100, 1, 0,64'h8000_0100,1,32'h0020_0113,64'h8000_0100);
    tbl[10] = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0100,0,32'h0020_0113,64'h8000_0100);
    tbl[11] = mk(0,0,32'h0,        1,64'h8000_0200, 1, 0,64'h8000_0100,0,32'h0020_0113,64'h8000_0100);
    tbl[12] = mk(0,0,32'h0,        0,64'h0,         1, 0,64'h8000_0200,0,32'h0020_0113,64'h8000_0100);
    tbl[13] = mk(0,1,32'hDEAD_BEEF,0,64'h0,         1, 0,64'h8000_0200,0,32'h0020_0113,64'h8000_0100);
    tbl[14] = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0200,0,32'h0020_0113,64'h8000_0100);
    tbl[15] = mk(0,1,32'h0030_0193,0,64'h0,         1, 0,64'h8000_0200,0,32'h0020_0113,64'h8000_0100);
    tbl[16] = mk(0,0,32'h0,        1,64'h8000_0300, 0, 0,64'h8000_0200,1,32'h0030_0193,64'h8000_0200);
    tbl[17] = mk(1,0,32'h0,        1,64'h8000_0400, 1, 1,64'h8000_0300,0,32'h0030_0193,64'h8000_0200);
    tbl[18] = mk(0,1,32'h1111_1111,0,64'h0,         1, 0,64'h8000_0400,0,32'h0030_0193,64'h8000_0200);
    tbl[19] = mk(1,0,32'h0,        0,64'h0,         1, 1,64'h8000_0400,0,32'h0030_0193,64'h8000_0200);
    tbl[20] = mk(0,1,32'h2222_2222,1,64'h8000_0500, 1, 0,64'h8000_0400,0,32'h0030_0193,64'h8000_0200);
    tbl[21] = mk(0,0,32'h0,        1,64'hFFFF_FFFF_FFFF_FFFF,1, 1,64'h8000_0500,0,32'h0030_0193,64'h8000_0200);
    tbl[22] = mk(1,0,32'h0,        0,64'h0,         1, 1,64'hFFFF_FFFF_FFFF_FFFC,0,32'h0030_0193,64'h8000_0200);
    tbl[23] = mk(0,1,32'h0040_0213,0,64'h0,         1, 0,64'hFFFF_FFFF_FFFF_FFFC,0,32'h0030_0193,64'h8000_0200);
    tbl[24] = mk(0,0,32'h0,        0,64'h0,         1, 0,64'hFFFF_FFFF_FFFF_FFFC,1,32'h0040_0213,64'hFFFF_FFFF_FFFF_FFFC);
    tbl[25] = mk(0,0,32'h0,        0,64'h0,         1, 1,64'h0,0,32'h0040_0213,64'hFFFF_FFFF_FFFF_FFFC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cycle table: outputs checked before this row's inputs take effect.
    for (int i = 0; i < 26; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("tbl%0d req_valid", i), 64'(req_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d req_addr", i), req_addr, tbl[i].ea);
      chk($sformatf("tbl%0d inst_valid", i), 64'(inst_valid), 64'(tbl[i].eiv));
      chk($sformatf("tbl%0d inst", i), 64'(inst), 64'(tbl[i].ei));
      chk($sformatf("tbl%0d pc_o", i), pc_o, tbl[i].ep);
      drive(tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].ps, tbl[i].tg, tbl[i].ir);
    end

    // Decode stall: buffered instruction held for 5 cycles, then consumed.
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 64'h0, 0);
    @(negedge clk);
    drive(0, 1, 32'h0000_0013, 0, 64'h0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d inst_valid", k), 64'(inst_valid), 64'h1);
      chk($sformatf("hold%0d inst", k), 64'(inst), 64'h13);
      chk($sformatf("hold%0d pc_o", k), pc_o, 64'h0);
      chk($sformatf("hold%0d req_valid", k), 64'(req_valid), 64'h0);
      drive(0, 0, 32'h0, 0, 64'h0, (k == 5));
    end
    @(negedge clk);
    chk("hold_next req_valid", 64'(req_valid), 64'h1);
    chk("hold_next req_addr", req_addr, 64'h4);
    chk("hold_next inst_valid", 64'(inst_valid), 64'h0);

    // Reset asserted while waiting; the late response must be ignored.
    drive(1, 0, 32'h0, 0, 64'h0, 0);
    @(negedge clk);
    chk("rstw wait req_valid", 64'(req_valid), 64'h0);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 64'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw0 req_valid", 64'(req_valid), 64'h1);
    chk("rstw0 req_addr", req_addr, 64'h8000_0000);
    drive(0, 1, 32'hABCD_1234, 0, 64'h0, 0);
    @(negedge clk);
    chk("rstw1 req_valid", 64'(req_valid), 64'h1);
    chk("rstw1 req_addr", req_addr, 64'h8000_0000);
    chk("rstw1 inst_valid", 64'(inst_valid), 64'h0);
    chk("rstw1 inst", 64'(inst), 64'h0);
    chk("rstw1 pc_o", pc_o, 64'h0);
    drive(0, 0, 32'h0, 0, 64'h0, 0);

    // Randomized run against the fetch model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc    = 64'h8000_0000;
    m_outst = 1'b0;
    m_live  = 1'b0;
    m_out_addr = 64'h0;
    m_buf   = 1'b0;
    m_buf_pc = 64'h0;
    m_buf_inst = 32'h0;
    m_deliv = 0;
    for (int c = 0; c < 4000; c++) begin
      logic        exp_req;
      logic        rr, rv, ps, ir;
      logic [63:0] tg;
      logic        old_buf;
      if (c > 0) @(negedge clk);
      exp_req = !m_outst && !m_buf;
      chk("rnd req_valid", 64'(req_valid), 64'(exp_req));
      if (exp_req) chk("rnd req_addr", req_addr, m_pc);
      chk("rnd inst_valid", 64'(inst_valid), 64'(m_buf));
      if (m_buf) begin
        chk("rnd inst", 64'(inst), 64'(m_buf_inst));
        chk("rnd pc_o", pc_o, m_buf_pc);
      end
      rr = ($urandom % 4) != 0;
      rv = m_outst && (($urandom % 2) == 0);
      ps = ($urandom % 10) == 0;
      ir = ($urandom % 3) != 0;
      if (($urandom % 4) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
      else                     tg = {$urandom, $urandom};
      drive(rr, rv, mem_word(m_out_addr), ps, tg, ir);

      old_buf = m_buf;
      if (exp_req && rr) begin
        m_outst    = 1'b1;
        m_out_addr = m_pc;
        m_live     = 1'b1;
      end else if (m_outst && rv) begin
        if (m_live && !ps) begin
          m_buf      = 1'b1;
          m_buf_pc   = m_out_addr;
          m_buf_inst = mem_word(m_out_addr);
        end
        m_outst = 1'b0;
      end
      if (old_buf && ir) begin
        m_buf   = 1'b0;
        m_pc    = m_buf_pc + 64'd4;
        m_deliv++;
      end
      if (ps) begin
        m_pc   = tg & ~64'd3;
        m_live = 1'b0;
        if (old_buf) m_buf = 1'b0;
      end
    end
    chk("rnd progress", 64'(m_deliv > 50), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
